spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_master_if.sv | 24 ++
 rtl/spi_clk_div.sv | 28 ++
 rtl/spi_master.sv | 108 ++++++++++
 tb/tb_spi_master.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding and default geometry.
// Also imported by spi_slave benches so they agree on the defaults.
package spi_pkg;

    localparam int SPI_DATA_W  = 8;
    localparam int SPI_CLK_DIV = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCLK_HI,
        ST_SCLK_LO,
        ST_HOLD
    } spi_state_t;

endpackage

// File: rtl/spi_master_if.sv
// Host handshake plus SPI pins for one SPI link.
interface spi_master_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;
    logic              SCLK;
    logic              CS;
    logic              MOSI;
    logic              MISO;

    modport master (
        input  start, tx_data, MISO,
        output rx_data, busy, done, SCLK, CS, MOSI
    );

    modport slave (
        output start, tx_data, MISO,
        input  rx_data, busy, done, SCLK, CS, MOSI
    );
endinterface

// File: rtl/spi_clk_div.sv
// Half-period timer: reloads while disabled, ticks on the last cycle of each
// CLK_DIV-cycle window while enabled.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || cnt == 8'd0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 8'd1;
        end
    end

    assign tick = en && (cnt == 8'd0);
endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, one word per start.
// All pin outputs come straight from flops.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV,
    parameter int DATA_W  = SPI_DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_master_if.master  bus
);
    localparam int BIT_CNT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W);

    spi_state_t           state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [DATA_W-1:0]    tx_sr;
    logic [DATA_W-1:0]    rx_sr;
    logic [DATA_W-1:0]    rx_q;
    logic [DATA_W-1:0]    tx_next;
    logic [DATA_W-1:0]    rx_shift;
    logic                 tick;
    logic                 sclk_q;
    logic                 cs_q;
    logic                 mosi_q;
    logic                 busy_q;
    logic                 done_q;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state != ST_IDLE),
        .tick  (tick)
    );

    assign tx_next  = tx_sr << 1;
    assign rx_shift = (rx_sr << 1) | DATA_W'(bus.MISO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: if (bus.start) begin
                    state   <= ST_SETUP;
                    cs_q    <= 1'b0;
                    busy_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                    mosi_q  <= bus.tx_data[DATA_W-1];
                    tx_sr   <= bus.tx_data;
                    bit_cnt <= '0;
                end
                ST_SETUP: if (tick) begin
                    sclk_q  <= 1'b1;
                    rx_sr   <= rx_shift;
                    bit_cnt <= bit_cnt + 1'b1;
                    state   <= ST_SCLK_HI;
                end
                ST_SCLK_HI: if (tick) begin
                    sclk_q <= 1'b0;
                    state  <= ST_SCLK_LO;
                    if (bit_cnt != LAST_BIT) begin
                        tx_sr  <= tx_next;
                        mosi_q <= tx_next[DATA_W-1];
                    end
                end
                // The last bit still gets a full low half-period before HOLD.
                ST_SCLK_LO: if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        state <= ST_HOLD;
                    end else begin
                        sclk_q  <= 1'b1;
                        rx_sr   <= rx_shift;
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= ST_SCLK_HI;
                    end
                end
                ST_HOLD: if (tick) begin
                    cs_q   <= 1'b1;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    mosi_q <= 1'b0;
                    rx_q   <= rx_sr;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.SCLK    = sclk_q;
    assign bus.CS      = cs_q;
    assign bus.MOSI    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: CLK_DIV=2 instance with loopback/driven MISO, and a
// CLK_DIV=1 instance talking to a behavioural mode-0 slave.
module tb_spi_master;
    localparam int W     = 8;
    localparam int DIV   = 2;
    localparam int CS_LO = (2 * W + 2) * DIV;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_if #(.DATA_W(W)) bus0 ();
    spi_master_if #(.DATA_W(W)) bus1 ();

    spi_master #(.CLK_DIV(DIV), .DATA_W(W)) u_dut (
        .clk (clk), .rst_n (rst_n), .bus (bus0.master)
    );
    spi_master #(.CLK_DIV(1), .DATA_W(W)) u_dut_fast (
        .clk (clk), .rst_n (rst_n), .bus (bus1.master)
    );

    int checks = 0;
    int errors = 0;

    logic loopback = 1'b1;
    logic miso_drv = 1'b0;
    assign bus0.MISO = loopback ? bus0.MOSI : miso_drv;

    // Mode-0 slave: MISO valid before the first rising edge, shifts on falling edges.
    logic [W-1:0] slv_in    = 8'hC3;
    logic [W-1:0] slv_shift = '0;
    logic [W-1:0] slv_out   = '0;
    assign bus1.MISO = slv_shift[W-1];
    always @(negedge bus1.CS) slv_shift <= slv_in;
    always @(posedge bus1.SCLK) if (bus1.CS === 1'b0) slv_out <= {slv_out[W-2:0], bus1.MOSI};
    always @(negedge bus1.SCLK) if (bus1.CS === 1'b0) slv_shift <= slv_shift << 1;

    // Per-transfer observations filled by watch()
    logic [W-1:0] exp_miso [4];
    logic [W-1:0] obs_mosi [4];
    logic [W-1:0] obs_rx   [4];
    int obs_cslow [4];
    int obs_rise  [4];
    int obs_gap   [4];
    int n_seen, busy_bad, mosi_hi, rx_glitch;

    task automatic watch(input int n, input int budget);
        int x = 0, k = 0, cs_low = 0, gap = 0, cyc = 0;
        logic prev_sclk = 1'b0, prev_cs = 1'b1;
        logic [W-1:0] mw = '0;
        logic [W-1:0] rx_prev = bus0.rx_data;
        busy_bad = 0; mosi_hi = 0; rx_glitch = 0;
        for (int i = 0; i < 4; i++) begin
            obs_mosi[i] = 'x; obs_rx[i] = 'x; obs_cslow[i] = -1; obs_rise[i] = -1; obs_gap[i] = -1;
        end
        miso_drv = exp_miso[0][W-1];
        while (x < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus0.done === 1'b1) begin
                obs_rx[x] = bus0.rx_data; obs_mosi[x] = mw;
                obs_cslow[x] = cs_low; obs_rise[x] = k;
                rx_prev = bus0.rx_data;
                x++; k = 0; cs_low = 0; mw = '0; gap = 0;
            end else if (bus0.rx_data !== rx_prev) begin
                rx_glitch++;
            end
            if (bus0.CS === 1'b1) begin
                gap++;
                if (bus0.busy !== 1'b0) busy_bad++;
            end else begin
                if (prev_cs && x < 4) obs_gap[x] = gap;
                cs_low++;
                if (bus0.busy !== 1'b1) busy_bad++;
                if (bus0.MOSI === 1'b1) mosi_hi++;
            end
            if (bus0.SCLK === 1'b1 && !prev_sclk) begin
                mw = {mw[W-2:0], bus0.MOSI};
                k++;
            end
            if (x < 4 && k < W) miso_drv = exp_miso[x][W-1-k];
            else miso_drv = 1'b0;
            prev_sclk = bus0.SCLK;
            prev_cs   = bus0.CS;
        end
        n_seen = x;
    endtask

    task automatic kick(input logic [W-1:0] tx);
        @(negedge clk);
        bus0.start = 1'b1; bus0.tx_data = tx;
        @(negedge clk);
        bus0.start = 1'b0;
        bus0.tx_data = W'($urandom);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus0.CS !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b expected 1", bus0.CS); end
        checks++; if (bus0.SCLK !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", bus0.SCLK); end
        checks++; if (bus0.MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", bus0.MOSI); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus0.busy); end
        checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus0.done); end
        checks++; if (bus0.rx_data !== '0) begin errors++; $display("FAIL reset_rx: got %h expected 00", bus0.rx_data); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus0.CS !== 1'b1 || bus0.busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: cs=%b busy=%b expected cs=1 busy=0", bus0.CS, bus0.busy);
        end
    endtask

    task automatic test_loopback();
        int extra = 0;
        loopback = 1'b1; exp_miso[0] = 8'hA5;
        fork watch(1, 200); kick(8'hA5); join
        checks++; if (n_seen !== 1) begin errors++; $display("FAIL lb_done: got %0d transfers expected 1", n_seen); end
        checks++; if (obs_cslow[0] !== CS_LO) begin errors++; $display("FAIL lb_cs_low: got %0d expected %0d", obs_cslow[0], CS_LO); end
        checks++; if (obs_mosi[0] !== 8'hA5) begin errors++; $display("FAIL lb_mosi: got %h expected a5", obs_mosi[0]); end
        checks++; if (obs_rx[0] !== 8'hA5) begin errors++; $display("FAIL lb_rx: got %h expected a5", obs_rx[0]); end
        checks++; if (busy_bad !== 0) begin errors++; $display("FAIL lb_busy: got %0d bad cycles expected 0", busy_bad); end
        repeat (10) begin @(negedge clk); if (bus0.done === 1'b1 || bus0.CS !== 1'b1) extra++; end
        checks++; if (extra !== 0 || bus0.rx_data !== 8'hA5) begin
            errors++; $display("FAIL lb_quiet: extra=%0d rx=%h expected 0 and a5", extra, bus0.rx_data);
        end
    endtask

    task automatic test_miso_ones();
        loopback = 1'b0; exp_miso[0] = 8'hFF;
        fork watch(1, 200); kick(8'h00); join
        checks++; if (obs_rx[0] !== 8'hFF) begin errors++; $display("FAIL ones_rx: got %h expected ff", obs_rx[0]); end
        checks++; if (mosi_hi !== 0) begin errors++; $display("FAIL ones_mosi: got %0d high cycles expected 0", mosi_hi); end
        checks++; if (obs_rise[0] !== W) begin errors++; $display("FAIL ones_rises: got %0d expected %0d", obs_rise[0], W); end
    endtask

    task automatic test_random();
        logic [W-1:0] t;
        loopback = 1'b0;
        for (int it = 0; it < 6; it++) begin
            t = W'($urandom);
            exp_miso[0] = W'($urandom);
            fork watch(1, 200); kick(t); join
            checks++; if (obs_mosi[0] !== t || obs_rx[0] !== exp_miso[0]) begin
                errors++; $display("FAIL rand_data[%0d]: mosi=%h rx=%h expected mosi=%h rx=%h", it, obs_mosi[0], obs_rx[0], t, exp_miso[0]);
            end
            checks++; if (obs_cslow[0] !== CS_LO || obs_rise[0] !== W) begin
                errors++; $display("FAIL rand_timing[%0d]: cs_low=%0d rises=%0d expected %0d and %0d", it, obs_cslow[0], obs_rise[0], CS_LO, W);
            end
            checks++; if (rx_glitch !== 0 || busy_bad !== 0) begin
                errors++; $display("FAIL rand_hold[%0d]: rx_changes=%0d busy_bad=%0d expected 0 and 0", it, rx_glitch, busy_bad);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [3];
        words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'h3C;
        loopback = 1'b1; exp_miso[0] = '0;
        fork
            watch(3, 400);
            begin
                @(negedge clk); bus0.start = 1'b1; bus0.tx_data = words[0];
                @(negedge clk); bus0.tx_data = words[1];
                for (int c = 0; c < 200 && bus0.done !== 1'b1; c++) @(negedge clk);
                @(negedge clk); bus0.tx_data = words[2];
                for (int c = 0; c < 200 && bus0.done !== 1'b1; c++) @(negedge clk);
                @(negedge clk); bus0.start = 1'b0;
            end
        join
        checks++; if (n_seen !== 3) begin errors++; $display("FAIL b2b_count: got %0d done pulses expected 3", n_seen); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (obs_mosi[i] !== words[i] || obs_rx[i] !== words[i] || obs_cslow[i] !== CS_LO) begin
                errors++; $display("FAIL b2b_xfer[%0d]: mosi=%h rx=%h cs_low=%0d expected %h %h %0d", i, obs_mosi[i], obs_rx[i], obs_cslow[i], words[i], words[i], CS_LO);
            end
        end
        for (int i = 1; i < 3; i++) begin
            checks++; if (obs_gap[i] !== 1) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d expected 1", i, obs_gap[i]); end
        end
    endtask

    task automatic test_start_while_busy();
        logic [W-1:0] t;
        int extra = 0;
        int seen_hi = 0;
        t = W'($urandom);
        loopback = 1'b0; exp_miso[0] = W'($urandom) | 8'h01;
        fork
            watch(1, 200);
            kick(t);
            begin
                for (int c = 0; c < 100 && bus0.SCLK !== 1'b1; c++) @(negedge clk);
                seen_hi = (bus0.SCLK === 1'b1) ? 1 : 0;
                bus0.tx_data = ~t; bus0.start = 1'b1;
                @(negedge clk); bus0.start = 1'b0;
            end
        join
        checks++; if (seen_hi !== 1) begin errors++; $display("FAIL busy_sclk_hi: got %0d expected 1", seen_hi); end
        checks++; if (n_seen !== 1 || obs_mosi[0] !== t || obs_rx[0] !== exp_miso[0] || obs_cslow[0] !== CS_LO) begin
            errors++; $display("FAIL busy_xfer: n=%0d mosi=%h rx=%h cs_low=%0d expected 1 %h %h %0d", n_seen, obs_mosi[0], obs_rx[0], obs_cslow[0], t, exp_miso[0], CS_LO);
        end
        repeat (20) begin @(negedge clk); if (bus0.CS !== 1'b1 || bus0.done === 1'b1) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL busy_ignored: got %0d active cycles expected 0", extra); end
    endtask

    task automatic test_reset_mid();
        int rises = 0, spurious = 0;
        logic prev_sclk = 1'b0;
        logic [W-1:0] t;
        loopback = 1'b0; miso_drv = 1'b1;
        @(negedge clk); bus0.start = 1'b1; bus0.tx_data = W'($urandom);
        @(negedge clk); bus0.start = 1'b0;
        for (int c = 0; c < 100 && rises < 4; c++) begin
            @(negedge clk);
            if (bus0.SCLK === 1'b1 && !prev_sclk) rises++;
            prev_sclk = bus0.SCLK;
        end
        checks++; if (rises !== 4) begin errors++; $display("FAIL rst_mid_rises: got %0d expected 4", rises); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus0.CS !== 1'b1 || bus0.SCLK !== 1'b0 || bus0.busy !== 1'b0 || bus0.MOSI !== 1'b0) begin
            errors++; $display("FAIL rst_mid_pins: cs=%b sclk=%b busy=%b mosi=%b expected 1 0 0 0", bus0.CS, bus0.SCLK, bus0.busy, bus0.MOSI);
        end
        checks++; if (bus0.rx_data !== '0) begin errors++; $display("FAIL rst_mid_rx: got %h expected 00", bus0.rx_data); end
        repeat (3) begin @(negedge clk); if (bus0.done !== 1'b0) spurious++; end
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); if (bus0.done !== 1'b0 || bus0.CS !== 1'b1) spurious++; end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL rst_mid_done: got %0d bad cycles expected 0", spurious); end
        t = W'($urandom);
        loopback = 1'b1; exp_miso[0] = '0;
        fork watch(1, 200); kick(t); join
        checks++; if (n_seen !== 1 || obs_rx[0] !== t || obs_cslow[0] !== CS_LO) begin
            errors++; $display("FAIL rst_mid_restart: n=%0d rx=%h cs_low=%0d expected 1 %h %0d", n_seen, obs_rx[0], obs_cslow[0], t, CS_LO);
        end
    endtask

    task automatic test_clkdiv1();
        int cs_low = 0, rises = 0, bad_period = 0, last_rise = -1, cyc = 0, got_done = 0;
        logic prev_sclk = 1'b0;
        @(negedge clk); bus1.start = 1'b1; bus1.tx_data = 8'h5A;
        @(negedge clk); bus1.start = 1'b0; bus1.tx_data = 8'hFF;
        for (int c = 0; c < 100 && got_done == 0; c++) begin
            if (bus1.CS === 1'b0) cs_low++;
            if (bus1.SCLK === 1'b1 && !prev_sclk) begin
                if (last_rise >= 0 && cyc - last_rise != 2) bad_period++;
                last_rise = cyc; rises++;
            end
            prev_sclk = bus1.SCLK;
            if (bus1.done === 1'b1) got_done = 1;
            @(negedge clk); cyc++;
        end
        checks++; if (got_done !== 1) begin errors++; $display("FAIL fast_done: got %0d expected 1", got_done); end
        checks++; if (slv_out !== 8'h5A) begin errors++; $display("FAIL fast_slave_out: got %h expected 5a", slv_out); end
        checks++; if (bus1.rx_data !== 8'hC3) begin errors++; $display("FAIL fast_rx: got %h expected c3", bus1.rx_data); end
        checks++; if (rises !== W || bad_period !== 0) begin
            errors++; $display("FAIL fast_sclk: rises=%0d bad_periods=%0d expected %0d and 0", rises, bad_period, W);
        end
        checks++; if (cs_low !== (2 * W + 2)) begin errors++; $display("FAIL fast_cs_low: got %0d expected %0d", cs_low, 2 * W + 2); end
    endtask

    initial begin
        bus0.start = 1'b0; bus0.tx_data = '0;
        bus1.start = 1'b0; bus1.tx_data = '0;
        test_reset();
        test_loopback();
        test_miso_ones();
        test_random();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid();
        test_clkdiv1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1);
    end
endmodule
